mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single synchronous data-RAM port between the RV32I core's load/store port and a word-wide loader/DMA requester, such as a UART boot loader. Sits between the core data bus and the RAM. It generates the core's clock enable, so the core stalls while the loader owns the port. Each RAM read is tagged with its issuer, so returning read data goes back to the correct requester.

## Interface
Parameters:
- RD_LAT, 2: fixed RAM read latency in cycles (≥1).
- WAIT_MAX, 16: maximum cycles a pending loader request waits behind core traffic.
- BURST_MAX, 8: maximum loader beats per tenure.

Ports (reset rstB, synchronous, active-low; clock clk):
- clk  in  1  clock
- rstB  in  1  synchronous active-low reset
- en_in  in  1  global clock enable
- core_clkEn  out  1  clock enable to core
- core_addr  in  32  core byte address
- core_wdata  in  32  core store data
- core_wrEn  in  1  core store strobe
- core_rdEn  in  1  core load strobe
- core_mode  in  4  {byte,half,word,unsigned}
- core_rdata  out  32  load data to core
- core_rvalid  out  1  core load data valid pulse
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write (1) / read (0)
- ldr_addr  in  32  loader byte address
- ldr_wdata  in  32  loader write data
- ldr_gnt  out  1  loader beat accepted this cycle
- ldr_rdata  out  32  loader read data
- ldr_rvalid  out  1  loader read data valid pulse
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_mode  out  4  RAM access mode
- ram_rdata  in  32  RAM read data, valid RD_LAT cycles after ram_re

## Operation
- core_req = core_rdEn | core_wrEn.
- FSM states:
  - S_CORE: the core drives the RAM port and core_clkEn = en_in. ram_we/ram_re/ram_mode/ram_addr/ram_wdata = core signals, gated by en_in.
  - S_LDR: the loader drives the port with ram_mode forced to 4'b0010 (word) and core_clkEn = 0. ldr_gnt = ldr_req & en_in, and a beat is accepted when ldr_gnt = 1.
- wait_cnt: counts S_CORE cycles with ldr_req=1 and en_in=1. It saturates at WAIT_MAX and clears on entry to S_LDR or when ldr_req=0.
- S_CORE→S_LDR at cycle end when en_in & ldr_req & (!core_req | wait_cnt==WAIT_MAX).
  - The core access issued in the switching cycle completes normally.
  - The core then stalls holding its request, which is served after return.
- burst_cnt: counts accepted beats in S_LDR and clears on entry to S_LDR.
- S_LDR→S_CORE at cycle end when en_in & (!ldr_req | (ldr_gnt & burst_cnt==BURST_MAX-1)).
- en_in=0 behaviour:
  - FSM, counters and tag pipe hold.
  - No RAM strobes are issued.
  - ldr_gnt=0 and core_clkEn=0.
- Read-return tag pipe: RD_LAT entries of {valid, owner}, pushed every en_in cycle.
  - On pop with valid=1, ram_rdata is registered into core_rdata or ldr_rdata according to owner, with a one-cycle rvalid pulse.
  - core_rdata/ldr_rdata hold their last value between pulses.
- Reads in flight across an ownership switch still return to their issuer.

## Timing
- Reset values:
  - FSM: S_CORE.
  - Counters: 0.
  - Tag pipe: all invalid.
  - core_rdata and ldr_rdata: 0.
  - core_rvalid, ldr_rvalid and ldr_gnt: 0.
  - core_clkEn: en_in.
- Arbitration and FSM outputs are combinational from registered state. Reset mid-burst aborts the burst and drops in-flight tags, so no rvalid pulse follows reset.
- Read latency is RD_LAT+1 cycles from the issuing cycle to rvalid, because of the registered return.
- Loader grant latency:
  - 1 cycle after ldr_req rises if the core is idle.
  - At most WAIT_MAX+1 cycles under continuous core traffic.
- Loader tenure is at most BURST_MAX beats. At least one S_CORE cycle follows every S_LDR tenure.
- If the core and the loader request simultaneously with wait_cnt<WAIT_MAX, the core wins.

## Structure
- A shared package holds:
  - the RAM mode constants (MODE_BYTE=4'b1000, MODE_HALF=4'b0100, MODE_WORD=4'b0010, unsigned bit 0);
  - the owner enum (OWN_CORE, OWN_LDR);
  - the FSM state typedef.
- One sub-module, rd_tag_pipe: a parameterised RD_LAT-deep valid/owner shift register with enable.

## Test plan
- Core-only: core_rdEn at 0x100 with ram_rdata=0xDEADBEEF → core_rvalid 3 cycles later (RD_LAT=2) with core_rdata=0xDEADBEEF, and ldr_rvalid stays 0.
- Loader with idle core: ldr_req with 3 write beats → ldr_gnt high on 3 consecutive cycles, then 1 cycle later core_clkEn=0. After ldr_req drops, core_clkEn returns to 1 and ram_mode=4'b0010 throughout the beats.
- Starvation: continuous core_rdEn and ldr_req held → ldr_gnt first asserted 17 cycles after ldr_req (WAIT_MAX=16), and wait_cnt clears.
- Burst cap: ldr_req held for 20 beats → exactly 8 grants, then at least one S_CORE cycle serving the pending core request, then the loader resumes.
- Ownership switch with reads in flight: a core read issued on the switching cycle, followed by loader reads → the core read returns on core_rvalid only and the loader reads return on ldr_rvalid, in order.
- Reset/enable: rstB low mid-burst → next cycle S_CORE with no rvalid pulses. en_in=0 for 4 cycles → no ram_re/ram_we, counters frozen, and a pending read returns after en_in resumes.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter between the core
// load/store port and the word-wide loader.
package mem_bus_arbiter_pkg;

    localparam logic [3:0] MODE_BYTE = 4'b1000;
    localparam logic [3:0] MODE_HALF = 4'b0100;
    localparam logic [3:0] MODE_WORD = 4'b0010;
    localparam int         MODE_UNSIGNED_BIT = 0;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LDR  = 1'b1
    } owner_t;

    typedef enum logic {
        S_CORE = 1'b0,
        S_LDR  = 1'b1
    } arb_state_t;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rd_tag_pipe.sv
// Read-return tag pipe: tracks which requester issued each outstanding RAM read
// so the data can be steered back when it emerges DEPTH cycles later.
module rd_tag_pipe
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rstB,
    input  logic   en,
    input  logic   push_valid,
    input  owner_t push_owner,
    output logic   pop_valid,
    output owner_t pop_owner
);

    logic [DEPTH-1:0] r_valid;
    owner_t           r_owner [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_owner[i] <= OWN_CORE;
            end
        end else if (en) begin
            r_valid[0] <= push_valid;
            r_owner[0] <= push_owner;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_owner[i] <= r_owner[i-1];
            end
        end
    end

    assign pop_valid = r_valid[DEPTH-1];
    assign pop_owner = r_owner[DEPTH-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single synchronous data-RAM port between the core and a loader,
// stalling the core through core_clkEn while the loader owns the port.
//
// state  | meaning
// S_CORE | core drives the RAM port; a pending loader request ages in wait_cnt
// S_LDR  | loader drives the port in word mode; core is stalled
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int RD_LAT    = 2,
    parameter int WAIT_MAX  = 16,
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rstB,
    input  logic        en_in,
    output logic        core_clkEn,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_wrEn,
    input  logic        core_rdEn,
    input  logic [3:0]  core_mode,
    output logic [31:0] core_rdata,
    output logic        core_rvalid,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic [31:0] ldr_rdata,
    output logic        ldr_rvalid,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    output logic [3:0]  ram_mode,
    input  logic [31:0] ram_rdata
);

    localparam int WCW = cnt_width(WAIT_MAX);
    localparam int BCW = cnt_width(BURST_MAX);
    localparam logic [WCW-1:0] WAIT_SAT   = WCW'(WAIT_MAX);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_MAX - 1);

    arb_state_t       r_state;
    logic [WCW-1:0]   r_wait_cnt;
    logic [BCW-1:0]   r_burst_cnt;
    logic [31:0]      r_core_rdata;
    logic [31:0]      r_ldr_rdata;
    logic             r_core_rvalid;
    logic             r_ldr_rvalid;

    logic             w_core_req;
    logic             w_ldr_gnt;
    logic             w_to_ldr;
    logic             w_to_core;
    logic             w_pop_valid;
    owner_t           w_pop_owner;
    owner_t           w_push_owner;

    assign w_core_req = core_rdEn | core_wrEn;
    assign w_ldr_gnt  = (r_state == S_LDR) & ldr_req & en_in;
    assign w_to_ldr   = (r_state == S_CORE) & en_in & ldr_req
                      & (~w_core_req | (r_wait_cnt == WAIT_SAT));
    assign w_to_core  = (r_state == S_LDR) & en_in
                      & (~ldr_req | (w_ldr_gnt & (r_burst_cnt == BURST_LAST)));

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_state     <= S_CORE;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else if (en_in) begin
            case (r_state)
                S_CORE: begin
                    if (w_to_ldr) begin
                        r_state     <= S_LDR;
                        r_wait_cnt  <= '0;
                        r_burst_cnt <= '0;
                    end else if (!ldr_req) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != WAIT_SAT) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_LDR: begin
                    if (w_to_core) begin
                        r_state <= S_CORE;
                    end
                    if (w_ldr_gnt) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_state <= S_CORE;
            endcase
        end
    end

    // Port mux; every strobe is qualified by en_in so a frozen cycle issues nothing.
    always_comb begin
        core_clkEn   = 1'b0;
        ldr_gnt      = w_ldr_gnt;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_mode     = '0;
        w_push_owner = OWN_CORE;
        case (r_state)
            S_CORE: begin
                core_clkEn = en_in;
                if (en_in) begin
                    ram_addr  = core_addr;
                    ram_wdata = core_wdata;
                    ram_we    = core_wrEn;
                    ram_re    = core_rdEn;
                    ram_mode  = core_mode;
                end
            end
            S_LDR: begin
                ram_addr     = ldr_addr;
                ram_wdata    = ldr_wdata;
                ram_we       = w_ldr_gnt & ldr_we;
                ram_re       = w_ldr_gnt & ~ldr_we;
                ram_mode     = MODE_WORD;
                w_push_owner = OWN_LDR;
            end
            default: ;
        endcase
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rstB       (rstB),
        .en         (en_in),
        .push_valid (ram_re),
        .push_owner (w_push_owner),
        .pop_valid  (w_pop_valid),
        .pop_owner  (w_pop_owner)
    );

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_core_rdata  <= '0;
            r_ldr_rdata   <= '0;
            r_core_rvalid <= 1'b0;
            r_ldr_rvalid  <= 1'b0;
        end else begin
            r_core_rvalid <= 1'b0;
            r_ldr_rvalid  <= 1'b0;
            if (en_in && w_pop_valid) begin
                if (w_pop_owner == OWN_LDR) begin
                    r_ldr_rdata  <= ram_rdata;
                    r_ldr_rvalid <= 1'b1;
                end else begin
                    r_core_rdata  <= ram_rdata;
                    r_core_rvalid <= 1'b1;
                end
            end
        end
    end

    assign core_rdata  = r_core_rdata;
    assign core_rvalid = r_core_rvalid;
    assign ldr_rdata   = r_ldr_rdata;
    assign ldr_rvalid  = r_ldr_rvalid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small RD_LAT=2 RAM model whose read
// data is {addr[15:0], ~addr[15:0]}, except 0x100 which returns 0xDEADBEEF.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk;
    logic        rstB;
    logic        en_in;
    logic        core_clkEn;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_wrEn;
    logic        core_rdEn;
    logic [3:0]  core_mode;
    logic [31:0] core_rdata;
    logic        core_rvalid;
    logic        ldr_req;
    logic        ldr_we;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt;
    logic [31:0] ldr_rdata;
    logic        ldr_rvalid;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [3:0]  ram_mode;
    logic [31:0] ram_rdata;

    logic [31:0] r_ram_d0 = '0;
    logic [31:0] r_ram_d1 = '0;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int gcnt;
    int pulses;

    mem_bus_arbiter #(
        .RD_LAT    (2),
        .WAIT_MAX  (16),
        .BURST_MAX (8)
    ) dut (
        .clk         (clk),
        .rstB        (rstB),
        .en_in       (en_in),
        .core_clkEn  (core_clkEn),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_wrEn   (core_wrEn),
        .core_rdEn   (core_rdEn),
        .core_mode   (core_mode),
        .core_rdata  (core_rdata),
        .core_rvalid (core_rvalid),
        .ldr_req     (ldr_req),
        .ldr_we      (ldr_we),
        .ldr_addr    (ldr_addr),
        .ldr_wdata   (ldr_wdata),
        .ldr_gnt     (ldr_gnt),
        .ldr_rdata   (ldr_rdata),
        .ldr_rvalid  (ldr_rvalid),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_mode    (ram_mode),
        .ram_rdata   (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // RAM shares the global enable, so its latency freezes with the arbiter.
    always @(posedge clk) begin
        if (en_in) begin
            r_ram_d0 <= ram_re ? ram_val(ram_addr) : 32'h0;
            r_ram_d1 <= r_ram_d0;
        end
    end
    assign ram_rdata = r_ram_d1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstB       = 1'b0;
        en_in      = 1'b1;
        core_addr  = '0;
        core_wdata = '0;
        core_wrEn  = 1'b0;
        core_rdEn  = 1'b0;
        core_mode  = MODE_WORD;
        ldr_req    = 1'b0;
        ldr_we     = 1'b0;
        ldr_addr   = '0;
        ldr_wdata  = '0;

        // Reset state
        tick(); tick();
        rstB = 1'b1; #1;
        chk("rst_clkEn", core_clkEn, 1'b1);
        chk("rst_gnt", ldr_gnt, 1'b0);
        chk("rst_core_rvalid", core_rvalid, 1'b0);
        chk("rst_ldr_rvalid", ldr_rvalid, 1'b0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_ldr_rdata", ldr_rdata, 32'h0);
        chk("rst_ram_re", ram_re, 1'b0);

        // Core-only read at 0x100
        tick(); core_rdEn = 1'b1; core_addr = 32'h100; #1;
        chk("core_rd_re", ram_re, 1'b1);
        chk("core_rd_addr", ram_addr, 32'h100);
        chk("core_rd_mode", ram_mode, MODE_WORD);
        tick(); core_rdEn = 1'b0; #1;
        chk("core_rd_c1", core_rvalid, 1'b0);
        tick(); #1;
        chk("core_rd_c2", core_rvalid, 1'b0);
        tick(); #1;
        chk("core_rd_c3_valid", core_rvalid, 1'b1);
        chk("core_rd_c3_data", core_rdata, 32'hDEADBEEF);
        chk("core_rd_c3_ldr", ldr_rvalid, 1'b0);
        tick(); #1;
        chk("core_rd_c4_pulse", core_rvalid, 1'b0);
        chk("core_rd_c4_hold", core_rdata, 32'hDEADBEEF);

        // Loader writes with idle core
        core_mode = MODE_BYTE;
        tick(); ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h200; ldr_wdata = 32'h11111111; #1;
        chk("ldr_wr_req_gnt", ldr_gnt, 1'b0);
        chk("ldr_wr_req_clkEn", core_clkEn, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            ldr_addr  = 32'h200 + 32'(4 * i);
            ldr_wdata = 32'h11111111 * 32'(i + 1);
            #1;
            chk("ldr_wr_gnt", ldr_gnt, 1'b1);
            chk("ldr_wr_we", ram_we, 1'b1);
            chk("ldr_wr_re", ram_re, 1'b0);
            chk("ldr_wr_mode", ram_mode, 4'b0010);
            chk("ldr_wr_clkEn", core_clkEn, 1'b0);
            chk("ldr_wr_addr", ram_addr, 32'h200 + 32'(4 * i));
            chk("ldr_wr_wdata", ram_wdata, 32'h11111111 * 32'(i + 1));
        end
        tick(); ldr_req = 1'b0; #1;
        chk("ldr_wr_drop_clkEn", core_clkEn, 1'b0);
        chk("ldr_wr_drop_gnt", ldr_gnt, 1'b0);
        chk("ldr_wr_drop_we", ram_we, 1'b0);
        tick(); #1;
        chk("ldr_wr_back_clkEn", core_clkEn, 1'b1);

        // Starvation, then in-flight reads across the switch, then burst cap
        tick();
        core_rdEn = 1'b1; core_addr = 32'h300; core_mode = 4'b1001;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h400;
        #1;
        chk("starve_c0_gnt", ldr_gnt, 1'b0);
        lat = 0;
        while (ldr_gnt !== 1'b1 && lat < 40) begin
            tick(); #1;
            lat++;
        end
        chk("starve_latency", lat, 17);
        chk("starve_clkEn", core_clkEn, 1'b0);
        chk("starve_ram_re", ram_re, 1'b1);
        chk("starve_ram_addr", ram_addr, 32'h400);
        chk("starve_ram_mode", ram_mode, 4'b0010);
        gcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                tick(); ldr_addr = 32'h400 + 32'(4 * k); #1;
            end
            gcnt += int'(ldr_gnt);
            if (k == 2) begin
                chk("switch_core_rvalid", core_rvalid, 1'b1);
                chk("switch_core_rdata", core_rdata, 32'h0300FCFF);
                chk("switch_core_not_ldr", ldr_rvalid, 1'b0);
            end
            if (k == 3) begin
                chk("switch_ldr0_rvalid", ldr_rvalid, 1'b1);
                chk("switch_ldr0_rdata", ldr_rdata, 32'h0400FBFF);
                chk("switch_ldr0_not_core", core_rvalid, 1'b0);
            end
            if (k == 4) begin
                chk("switch_ldr1_rvalid", ldr_rvalid, 1'b1);
                chk("switch_ldr1_rdata", ldr_rdata, 32'h0404FBFB);
            end
        end
        chk("burst_grants", gcnt, 8);
        tick(); #1;
        chk("burst_end_gnt", ldr_gnt, 1'b0);
        chk("burst_end_clkEn", core_clkEn, 1'b1);
        chk("burst_end_core_re", ram_re, 1'b1);
        chk("burst_end_core_addr", ram_addr, 32'h300);
        lat = 0;
        while (ldr_gnt !== 1'b1 && lat < 40) begin
            tick(); #1;
            lat++;
        end
        chk("resume_latency", lat, 17);
        tick(); ldr_req = 1'b0; core_rdEn = 1'b0; #1;
        for (int i = 0; i < 4; i++) tick();

        // Reset in the middle of a loader read burst
        tick(); ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h500; #1;
        tick(); #1;
        chk("rst_burst_gnt", ldr_gnt, 1'b1);
        tick(); #1;
        tick(); rstB = 1'b0; #1;
        tick(); rstB = 1'b1; #1;
        chk("rst_burst_clkEn", core_clkEn, 1'b1);
        chk("rst_burst_gnt_off", ldr_gnt, 1'b0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick(); ldr_req = 1'b0; #1;
            end
            pulses += int'(core_rvalid) + int'(ldr_rvalid);
        end
        chk("rst_burst_no_rvalid", pulses, 0);

        // Global enable freeze with a core read in flight
        tick(); core_rdEn = 1'b1; core_addr = 32'h600; #1;
        chk("freeze_issue_re", ram_re, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); en_in = 1'b0; #1;
            chk("freeze_ram_re", ram_re, 1'b0);
            chk("freeze_ram_we", ram_we, 1'b0);
            chk("freeze_clkEn", core_clkEn, 1'b0);
            chk("freeze_rvalid", core_rvalid, 1'b0);
        end
        tick(); en_in = 1'b1; core_rdEn = 1'b0; #1;
        chk("unfreeze_c1", core_rvalid, 1'b0);
        tick(); #1;
        chk("unfreeze_c2", core_rvalid, 1'b0);
        tick(); #1;
        chk("unfreeze_c3_valid", core_rvalid, 1'b1);
        chk("unfreeze_c3_data", core_rdata, 32'h0600F9FF);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
